// File: rtl/dcache_line_wb.sv
// dcache_line_wb: single-line write-back data cache with burst fill and flush
// Ports: clk/reset_n (async, active-low); dcache_* CPU read/write requests;
// line_fill/line_flush/line_inval line control; line_out/line_valid/line_miss
// response one cycle after a request; line_busy/line_dirty status;
// mem_* burst interface (one-cycle rd/wr request pulse per burst, mem_valid
// paces fill data, mem_ready paces flush data).
module dcache_line_wb #(
  parameter int ADDRBITS  = 32,
  parameter int DATABITS  = 32,
  parameter int LINEWORDS = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDRBITS-1:0]   dcache_addr,
  input  logic [DATABITS-1:0]   dcache_datain,
  input  logic [DATABITS/8-1:0] dcache_be,
  input  logic                  dcache_rdreq,
  input  logic                  dcache_wrreq,
  input  logic                  line_fill,
  input  logic                  line_flush,
  input  logic                  line_inval,
  output logic [DATABITS-1:0]   line_out,
  output logic                  line_valid,
  output logic                  line_miss,
  output logic                  line_busy,
  output logic                  line_dirty,
  output logic [ADDRBITS-1:0]   mem_addr,
  output logic                  mem_rdreq,
  output logic                  mem_wrreq,
  input  logic [15:0]           mem_burstlen,
  input  logic [DATABITS-1:0]   mem_out,
  input  logic                  mem_valid,
  output logic [DATABITS-1:0]   mem_in,
  input  logic                  mem_ready
);
  localparam int OFFBITS = $clog2(LINEWORDS);
  localparam int TAGBITS = ADDRBITS - OFFBITS - 2;
  localparam int LANES   = DATABITS / 8;
  typedef enum logic [1:0] {INVALID, FILL, VALID, FLUSH} state_t;
  state_t state, state_n;
  logic [DATABITS-1:0] line_mem [LINEWORDS];
  logic [DATABITS-1:0] merged;
  logic [TAGBITS-1:0] tag, tag_n, ftag, req_tag, burst_tag;
  logic [OFFBITS-1:0] idx, cnt, bcnt, blen, blast, base;
  logic dirty, pend, miss_r, ctrl, rd, wr, hit, step, last_beat, last_word, enter, launch;
  logic unused_ok;
  assign unused_ok = ^dcache_addr[1:0];
  assign req_tag = dcache_addr[ADDRBITS-1:OFFBITS+2];
  assign idx = dcache_addr[OFFBITS+1:2];
  assign ctrl = line_inval | line_fill | line_flush;
  // a write wins over a simultaneous read
  assign wr = state == VALID && !ctrl && dcache_wrreq;
  assign rd = state == VALID && !ctrl && !dcache_wrreq && dcache_rdreq;
  assign hit = (rd || wr) && req_tag == tag;
  // one word moves per step: mem_valid paces fills, mem_ready paces flushes
  assign step = (state == FILL && mem_valid) || (state == FLUSH && mem_ready);
  assign last_beat = step && bcnt == blen;
  assign last_word = step && cnt == '1;
  assign enter = (state_n == FILL || state_n == FLUSH) && state_n != state;
  // the next burst is requested the cycle after the previous burst's last word
  assign launch = enter || (last_beat && !last_word);
  assign base = enter ? '0 : cnt + 1'b1;
  assign burst_tag = state_n == FLUSH ? tag : tag_n;
  // blen holds B-1; zero or oversize burst lengths mean one whole-line burst
  assign blast = (mem_burstlen == '0 || 32'(mem_burstlen) > LINEWORDS) ? OFFBITS'(LINEWORDS - 1) : OFFBITS'(mem_burstlen - 16'd1);
  assign line_busy = state == FILL || state == FLUSH;
  assign line_miss = state == INVALID || miss_r;
  assign line_dirty = dirty;
  assign mem_in = state == FLUSH ? line_mem[cnt] : '0;
  always_comb begin
    merged = line_mem[idx];
    for (int i = 0; i < LANES; i++)
      if (dcache_be[i]) merged[8*i +: 8] = dcache_datain[8*i +: 8];
  end
  always_comb begin
    state_n = state;
    tag_n = tag;
    case (state)
      INVALID: if (line_fill) begin state_n = FILL; tag_n = req_tag; end
      VALID:
        if (line_inval) state_n = INVALID;
        else if (line_fill) begin state_n = dirty ? FLUSH : FILL; tag_n = dirty ? tag : req_tag; end
        else if (line_flush && dirty) state_n = FLUSH;
      FILL: if (last_word) state_n = VALID;
      FLUSH: if (last_word) begin state_n = pend ? FILL : VALID; tag_n = pend ? ftag : tag; end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= INVALID;
      tag <= '0;
      ftag <= '0;
      pend <= 1'b0;
      dirty <= 1'b0;
      miss_r <= 1'b0;
      line_valid <= 1'b0;
      line_out <= '0;
      mem_rdreq <= 1'b0;
      mem_wrreq <= 1'b0;
      mem_addr <= '0;
      cnt <= '0;
      bcnt <= '0;
      blen <= '0;
    end else begin
      state <= state_n;
      tag <= tag_n;
      // a fill over a dirty line parks the new tag until the flush completes
      if (state == VALID && !line_inval && line_fill && dirty) begin
        ftag <= req_tag;
        pend <= 1'b1;
      end else if (state == FLUSH && last_word) pend <= 1'b0;
      if ((state == VALID && line_inval) || (state == FLUSH && last_word)) dirty <= 1'b0;
      else if (hit && wr) dirty <= 1'b1;
      line_valid <= hit;
      miss_r <= (rd || wr) && !hit;
      if (hit) line_out <= wr ? merged : line_mem[idx];
      mem_rdreq <= launch && state_n == FILL;
      mem_wrreq <= launch && state_n == FLUSH;
      if (launch) mem_addr <= {burst_tag, base, 2'b00};
      if (enter) begin
        cnt <= '0;
        bcnt <= '0;
        blen <= blast;
      end else if (step) begin
        cnt <= cnt + 1'b1;
        bcnt <= last_beat ? '0 : bcnt + 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (state == FILL && mem_valid) line_mem[cnt] <= mem_out;
    else if (hit && wr) line_mem[idx] <= merged;
endmodule

// File: tb/tb_dcache_line_wb.sv
// tb_dcache_line_wb: directed self-checking bench for dcache_line_wb
module tb_dcache_line_wb;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [31:0] dcache_addr, dcache_datain, line_out, mem_addr, mem_out, mem_in;
  logic [3:0] dcache_be;
  logic dcache_rdreq, dcache_wrreq, line_fill, line_flush, line_inval;
  logic line_valid, line_miss, line_busy, line_dirty, mem_rdreq, mem_wrreq, mem_valid, mem_ready;
  logic [15:0] mem_burstlen;
  always #5 clk = ~clk;
  dcache_line_wb dut (
    .clk(clk), .reset_n(reset_n),
    .dcache_addr(dcache_addr), .dcache_datain(dcache_datain), .dcache_be(dcache_be),
    .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq),
    .line_fill(line_fill), .line_flush(line_flush), .line_inval(line_inval),
    .line_out(line_out), .line_valid(line_valid), .line_miss(line_miss),
    .line_busy(line_busy), .line_dirty(line_dirty),
    .mem_addr(mem_addr), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq),
    .mem_burstlen(mem_burstlen), .mem_out(mem_out), .mem_valid(mem_valid),
    .mem_in(mem_in), .mem_ready(mem_ready)
  );
  typedef struct packed {logic v; logic m; logic [31:0] d;} exp_t;
  exp_t sq[$];
  logic [31:0] aq[$];
  logic [31:0] line_m [32];
  logic [24:0] tag_m = '0;
  bit vld_m = 0, dirty_m = 0;
  int checks = 0, errors = 0;
  function automatic logic [31:0] pat(input logic [24:0] t, input int k);
    return {t[7:0], 8'(k), 8'(k) ^ 8'h5A, 8'hC3};
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    int i = int'(a[6:2]);
    dcache_addr = a; dcache_datain = d; dcache_be = be; dcache_rdreq = rd; dcache_wrreq = wr;
    e = '{v: 1'b0, m: 1'b1, d: 32'h0};
    if (vld_m && a[31:7] == tag_m) begin
      if (wr) begin
        for (int j = 0; j < 4; j++) if (be[j]) line_m[i][8*j +: 8] = d[8*j +: 8];
        dirty_m = 1;
      end
      e = '{v: 1'b1, m: 1'b0, d: line_m[i]};
    end
    sq.push_back(e);
    @(posedge clk); #1;
    dcache_rdreq = 0; dcache_wrreq = 0;
    e = sq.pop_front();
    chk("line_valid", 64'(line_valid), 64'(e.v));
    chk("line_miss", 64'(line_miss), 64'(e.m));
    if (e.v) chk("line_out", 64'(line_out), 64'(e.d));
    chk("line_dirty", 64'(line_dirty), 64'(dirty_m));
  endtask
  task automatic ctrl(input bit f, input bit fl, input bit inv, input logic [31:0] a, input logic [15:0] bl);
    dcache_addr = a; line_fill = f; line_flush = fl; line_inval = inv; mem_burstlen = bl;
    @(posedge clk); #1;
    line_fill = 0; line_flush = 0; line_inval = 0;
  endtask
  task automatic do_fill(input logic [24:0] t, input int b);
    int beats = 0, words = 0, nreq = 0;
    logic [31:0] ea;
    for (int k = 0; k < 32; k += b) aq.push_back({t, 5'(k), 2'b00});
    chk("fill_busy", 64'(line_busy), 64'd1);
    for (int cyc = 0; cyc < 600 && words < 32; cyc++) begin
      mem_ready = 0;
      if (mem_rdreq) begin
        ea = aq.size() != 0 ? aq.pop_front() : 32'hFFFF_FFFF;
        chk("fill_addr", 64'(mem_addr), 64'(ea));
        nreq++; beats = b; mem_valid = 0;
      end else if (beats > 0) begin
        mem_out = pat(t, words); line_m[words] = mem_out; mem_valid = 1; words++; beats--;
      end else mem_valid = 0;
      @(posedge clk); #1;
    end
    mem_valid = 0;
    chk("fill_words", 64'(words), 64'd32);
    chk("fill_bursts", 64'(nreq), 64'(32 / b));
    chk("fill_done_busy", 64'(line_busy), 64'd0);
    chk("fill_done_miss", 64'(line_miss), 64'd0);
    chk("fill_done_dirty", 64'(line_dirty), 64'd0);
    tag_m = t; vld_m = 1; dirty_m = 0;
  endtask
  task automatic do_flush(input logic [24:0] t, input int b);
    int beats = 0, words = 0, nwr = 0;
    logic [31:0] ea;
    for (int k = 0; k < 32; k += b) aq.push_back({t, 5'(k), 2'b00});
    for (int cyc = 0; cyc < 1000 && words < 32; cyc++) begin
      if (mem_wrreq) begin
        ea = aq.size() != 0 ? aq.pop_front() : 32'hFFFF_FFFF;
        chk("flush_addr", 64'(mem_addr), 64'(ea));
        nwr++; beats = b;
      end
      if (beats > 0) begin
        mem_ready = 1'($urandom_range(0, 1));
        if (mem_ready) begin
          chk("flush_data", 64'(mem_in), 64'(line_m[words]));
          words++; beats--;
        end
      end else mem_ready = 0;
      @(posedge clk); #1;
    end
    chk("flush_words", 64'(words), 64'd32);
    chk("flush_bursts", 64'(nwr), 64'(32 / b));
    dirty_m = 0;
  endtask
  initial begin
    {dcache_addr, dcache_datain, dcache_be, dcache_rdreq, dcache_wrreq, line_fill, line_flush, line_inval} = '0;
    mem_burstlen = 16'd8; mem_out = '0; mem_valid = 0; mem_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_miss", 64'(line_miss), 64'd1);
    chk("rst_valid", 64'(line_valid), 64'd0);
    chk("rst_busy", 64'(line_busy), 64'd0);
    chk("rst_dirty", 64'(line_dirty), 64'd0);
    chk("rst_rdreq", 64'(mem_rdreq), 64'd0);
    chk("rst_wrreq", 64'(mem_wrreq), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_out", 64'(line_out), 64'd0);
    chk("rst_memin", 64'(mem_in), 64'd0);
    reset_n = 1;
    access(1, 0, 32'h0000_0814, 32'h0, 4'h0);
    ctrl(1, 0, 0, 32'h0000_0800, 16'd8);
    do_fill(25'h10, 8);
    @(posedge clk); #1;
    chk("idle_valid", 64'(line_valid), 64'd0);
    chk("idle_miss", 64'(line_miss), 64'd0);
    access(1, 0, 32'h0000_0814, 32'h0, 4'h0);
    chk("hit_word5", 64'(line_out), 64'(pat(25'h10, 5)));
    access(1, 0, 32'h0000_0894, 32'h0, 4'h0);
    access(0, 1, 32'h0000_080C, 32'h1122_3344, 4'hF);
    access(0, 1, 32'h0000_080C, 32'hAABB_CCDD, 4'b0010);
    chk("merge", 64'(line_out), 64'h1122_CC44);
    access(1, 1, 32'h0000_081C, 32'h5566_7788, 4'b0001);
    access(0, 1, 32'h0000_089C, 32'hDEAD_BEEF, 4'hF);
    access(1, 0, 32'h0000_081C, 32'h0, 4'h0);
    ctrl(1, 0, 0, 32'h0000_1000, 16'd4);
    do_flush(25'h10, 4);
    do_fill(25'h20, 4);
    access(1, 0, 32'h0000_1014, 32'h0, 4'h0);
    access(1, 0, 32'h0000_080C, 32'h0, 4'h0);
    ctrl(0, 1, 0, 32'h0000_1000, 16'd4);
    repeat (6) begin
      chk("clean_flush_quiet", 64'({mem_wrreq, mem_rdreq, line_busy}), 64'd0);
      @(posedge clk); #1;
    end
    access(0, 1, 32'h0000_1008, 32'hCAFE_F00D, 4'hF);
    ctrl(0, 1, 0, 32'h0000_1000, 16'd0);
    do_flush(25'h20, 32);
    mem_ready = 0;
    chk("flush_only_busy", 64'(line_busy), 64'd0);
    chk("flush_only_dirty", 64'(line_dirty), 64'd0);
    access(1, 0, 32'h0000_1008, 32'h0, 4'h0);
    access(0, 1, 32'h0000_1010, 32'h0BAD_F00D, 4'hF);
    ctrl(0, 0, 1, 32'h0000_1000, 16'd4);
    vld_m = 0; dirty_m = 0;
    chk("inval_miss", 64'(line_miss), 64'd1);
    chk("inval_dirty", 64'(line_dirty), 64'd0);
    repeat (5) begin
      chk("inval_quiet", 64'({mem_wrreq, mem_rdreq, line_busy}), 64'd0);
      @(posedge clk); #1;
    end
    access(1, 0, 32'h0000_1010, 32'h0, 4'h0);
    ctrl(1, 0, 0, 32'h0000_1800, 16'd0);
    do_fill(25'h30, 32);
    access(1, 0, 32'h0000_187C, 32'h0, 4'h0);
    ctrl(1, 0, 0, 32'h0000_2000, 16'd8);
    chk("midfill_rdreq", 64'(mem_rdreq), 64'd1);
    reset_n = 0;
    #1;
    chk("arst_miss", 64'(line_miss), 64'd1);
    chk("arst_rdreq", 64'(mem_rdreq), 64'd0);
    chk("arst_busy", 64'(line_busy), 64'd0);
    chk("arst_addr", 64'(mem_addr), 64'd0);
    chk("arst_valid", 64'(line_valid), 64'd0);
    aq.delete();
    vld_m = 0; dirty_m = 0;
    @(posedge clk); #1;
    reset_n = 1;
    access(1, 0, 32'h0000_2014, 32'h0, 4'h0);
    access(1, 0, 32'h0000_1814, 32'h0, 4'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
